// File: rtl/tone_pkg.sv
// Shared definitions for the tone measurement blocks: FSM state encoding,
// board clock rate and the nominal 440 Hz tone figures.
package tone_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CLK_HZ          = 25000000;
    localparam int TONE_440_PERIOD = 56818;    // 25 MHz / 440 Hz
    localparam int TONE_440_TOL    = 568;      // about 1 % of the period

    // True when |value - target| <= tol, using larger-minus-smaller so the
    // difference never wraps.
    function automatic logic within_tol(input logic [31:0] value,
                                        input logic [31:0] target,
                                        input logic [31:0] tol);
        logic [31:0] diff;
        diff = (value >= target) ? (value - target) : (target - value);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer plus a history flop for an asynchronous GPIO level.
// Produces the synchronized level and a one-cycle pulse on each rising edge.
module input_sync_edge (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic hist_reg;

    // Synchronizer chain and history flop; every edge sees the same delay.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign level = sync2_reg;
    assign rise  = sync2_reg & ~hist_reg;

endmodule

// File: rtl/tone_period_meter.sv
// Period meter for an audio-rate square wave: counts clock cycles between
// synchronized rising edges, averages 2^AVG_LOG2 periods per report, flags
// in-band reports against TARGET +/- TOL, tracks lock and signal loss.
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int AVG_LOG2    = 2,
    parameter int TARGET      = TONE_440_PERIOD,
    parameter int TOL         = TONE_440_TOL,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             TONE_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             IN_BAND,
    output logic             LOCKED,
    output logic             TIMEOUT
);

    // The accumulator carries AVG_LOG2 extra bits so the sum of 2^AVG_LOG2
    // full-scale samples cannot overflow. The index keeps one spare bit so it
    // is never zero width when AVG_LOG2 is 0.
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic tone_level;
    logic rise_pulse;
    logic tone_rise;

    input_sync_edge u_sync (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .async_in (TONE_IN),
        .level    (tone_level),
        .rise     (rise_pulse)
    );

    // A rise implies the synchronized level is already high.
    assign tone_rise = rise_pulse & tone_level;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       streak_reg;
    logic [CNT_W-1:0] period_reg;
    logic             valid_reg;
    logic             in_band_reg;
    logic             locked_reg;
    logic             timeout_reg;

    // Sum including the sample that arrives this cycle, its average and the
    // tolerance verdict on that average.
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] avg_next;
    logic             in_band_next;

    assign sum_next     = acc_reg + ACC_W'(cnt_reg);
    assign avg_next     = CNT_W'(sum_next >> AVG_LOG2);
    assign in_band_next = within_tol(32'(avg_next), 32'(TARGET), 32'(TOL));

    // Measurement FSM with counter, accumulator, report, lock and timeout.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            idx_reg     <= '0;
            streak_reg  <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
            in_band_reg <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            if (!ENABLE) begin
                // Partial average is discarded; PERIOD and IN_BAND hold.
                state_reg  <= IDLE;
                cnt_reg    <= '0;
                acc_reg    <= '0;
                idx_reg    <= '0;
                streak_reg <= '0;
                locked_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        acc_reg <= '0;
                        idx_reg <= '0;
                        if (tone_rise) begin
                            state_reg <= MEASURE;
                            cnt_reg   <= CNT_W'(1);
                        end else begin
                            cnt_reg <= '0;
                        end
                    end
                    MEASURE: begin
                        if (tone_rise) begin
                            // cnt equals the distance between the two rises.
                            cnt_reg <= CNT_W'(1);
                            if (idx_reg == IDX_LAST) begin
                                idx_reg     <= '0;
                                acc_reg     <= '0;
                                period_reg  <= avg_next;
                                valid_reg   <= 1'b1;
                                in_band_reg <= in_band_next;
                                if (in_band_next) begin
                                    if (streak_reg != 2'd2) begin
                                        streak_reg <= streak_reg + 2'd1;
                                    end
                                    if (streak_reg != 2'd0) begin
                                        locked_reg <= 1'b1;
                                    end
                                end else begin
                                    streak_reg <= '0;
                                    locked_reg <= 1'b0;
                                end
                            end else begin
                                idx_reg <= idx_reg + IDX_W'(1);
                                acc_reg <= sum_next;
                            end
                        end else if (cnt_reg == TIMEOUT_VAL) begin
                            // Signal lost: report it and forget everything.
                            timeout_reg <= 1'b1;
                            state_reg   <= IDLE;
                            cnt_reg     <= '0;
                            acc_reg     <= '0;
                            idx_reg     <= '0;
                            streak_reg  <= '0;
                            period_reg  <= '0;
                            in_band_reg <= 1'b0;
                            locked_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign PERIOD       = period_reg;
    assign PERIOD_VALID = valid_reg;
    assign IN_BAND      = in_band_reg;
    assign LOCKED       = locked_reg;
    assign TIMEOUT      = timeout_reg;

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomized scoreboard bench for tone_period_meter, run with scaled-down
// parameters so whole averaging windows and timeouts fit in a short run.
module tb_tone_period_meter;

    localparam int CNT_W    = 12;
    localparam int AVG_LOG2 = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int TARGET   = 100;
    localparam int TOL      = 3;
    localparam int TO_CYC   = 600;
    localparam int SYNC_LAT = 3;

    logic             CLOCK;
    logic             RESET_N;
    logic             ENABLE;
    logic             TONE_IN;
    logic [CNT_W-1:0] PERIOD;
    logic             PERIOD_VALID;
    logic             IN_BAND;
    logic             LOCKED;
    logic             TIMEOUT;

    tone_period_meter #(
        .CNT_W       (CNT_W),
        .AVG_LOG2    (AVG_LOG2),
        .TARGET      (TARGET),
        .TOL         (TOL),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .ENABLE       (ENABLE),
        .TONE_IN      (TONE_IN),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
        .IN_BAND      (IN_BAND),
        .LOCKED       (LOCKED),
        .TIMEOUT      (TIMEOUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endfunction

    // ---------------- reference model (rise-event level) ----------------
    typedef struct {
        bit is_to;
        int at;
        int period;
        bit inb;
        bit lock;
    } exp_t;

    exp_t exp_q[$];
    bit   m_active = 0;
    int   m_last   = 0;
    int   m_samples[$];
    int   m_streak = 0;
    int   m_period = 0;
    bit   m_inb    = 0;

    function automatic void m_push(bit is_to, int at, int p, bit inb, bit lock);
        exp_t e;
        e.is_to = is_to; e.at = at; e.period = p; e.inb = inb; e.lock = lock;
        exp_q.push_back(e);
    endfunction

    // A rise driven at cycle t.
    function automatic void m_rise(int t);
        int sum, avg, dev;
        if (!m_active) begin
            m_active = 1;
            m_samples.delete();
            m_last = t;
            return;
        end
        m_samples.push_back(t - m_last);
        m_last = t;
        if (m_samples.size() == NAVG) begin
            sum = 0;
            foreach (m_samples[i]) sum += m_samples[i];
            avg = sum / NAVG;
            dev = (avg > TARGET) ? avg - TARGET : TARGET - avg;
            m_inb = (dev <= TOL);
            m_streak = m_inb ? m_streak + 1 : 0;
            m_period = avg;
            m_push(0, t + SYNC_LAT, avg, m_inb, m_streak >= 2);
            m_samples.delete();
        end
    endfunction

    // Called once per cycle: a gap longer than the timeout means signal loss.
    function automatic void m_tick();
        if (m_active && (cyc - m_last == TO_CYC + 1)) begin
            m_push(1, m_last + SYNC_LAT + TO_CYC, 0, 0, 0);
            m_active = 0;
            m_streak = 0;
            m_period = 0;
            m_inb    = 0;
        end
    endfunction

    function automatic void m_forget();
        m_active = 0;
        m_streak = 0;
        m_samples.delete();
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge CLOCK) begin
        if (RESET_N && (PERIOD_VALID || TIMEOUT)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event cyc=%0d actual valid=%0b timeout=%0b period=%0d required no event",
                         cyc, PERIOD_VALID, TIMEOUT, PERIOD);
            end else begin
                mon_e = exp_q.pop_front();
                $display("event cyc=%0d valid=%0b timeout=%0b period=%0d in_band=%0b locked=%0b",
                         cyc, PERIOD_VALID, TIMEOUT, PERIOD, IN_BAND, LOCKED);
                chk("event_cycle", cyc, mon_e.at);
                chk("timeout_pulse", int'(TIMEOUT), int'(mon_e.is_to));
                chk("valid_pulse", int'(PERIOD_VALID), int'(!mon_e.is_to));
                chk("period", int'(PERIOD), mon_e.period);
                chk("in_band", int'(IN_BAND), int'(mon_e.inb));
                chk("locked", int'(LOCKED), int'(mon_e.lock));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLOCK);
        #1;
        m_tick();
    endtask

    // One period of the square wave, starting with its rising edge.
    task automatic tone_period(int p);
        TONE_IN = 1'b1;
        m_rise(cyc);
        repeat (p / 2) step();
        TONE_IN = 1'b0;
        repeat (p - p / 2) step();
    endtask

    task automatic hold_low(int n);
        TONE_IN = 1'b0;
        repeat (n) step();
    endtask

    task automatic in_band_tones(int n);
        for (int i = 0; i < n; i++) tone_period(TARGET - TOL + int'($urandom_range(2 * TOL)));
    endtask

    // One 100-cycle period with an ENABLE gap (kind 1) or a reset pulse
    // (kind 2) placed in its low phase.
    task automatic tone_with_event(int kind);
        int used;
        TONE_IN = 1'b1;
        m_rise(cyc);
        repeat (50) step();
        TONE_IN = 1'b0;
        repeat (5) step();
        if (kind == 1) begin
            ENABLE = 1'b0;
            m_forget();
            repeat (10) step();
            chk("gap_locked", int'(LOCKED), 0);
            chk("gap_period_hold", int'(PERIOD), m_period);
            chk("gap_in_band_hold", int'(IN_BAND), int'(m_inb));
            ENABLE = 1'b1;
            used = 15;
        end else begin
            RESET_N = 1'b0;
            #1;
            m_forget();
            m_period = 0;
            m_inb    = 0;
            chk("rst_period", int'(PERIOD), 0);
            chk("rst_valid", int'(PERIOD_VALID), 0);
            chk("rst_in_band", int'(IN_BAND), 0);
            chk("rst_locked", int'(LOCKED), 0);
            chk("rst_timeout", int'(TIMEOUT), 0);
            repeat (3) step();
            RESET_N = 1'b1;
            used = 8;
        end
        repeat (50 - used) step();
    endtask

    initial begin
        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        TONE_IN = 1'b0;
        repeat (4) step();
        chk("reset_period", int'(PERIOD), 0);
        chk("reset_valid", int'(PERIOD_VALID), 0);
        chk("reset_in_band", int'(IN_BAND), 0);
        chk("reset_locked", int'(LOCKED), 0);
        chk("reset_timeout", int'(TIMEOUT), 0);
        RESET_N = 1'b1;
        step();
        ENABLE = 1'b1;
        repeat (3) step();

        // Steady in-band tone: three reports, lock on the second.
        in_band_tones(13);
        // Fixed group averaging with truncation, then an out-of-band group.
        tone_period(98); tone_period(100); tone_period(102); tone_period(101);
        for (int i = 0; i < 4; i++) tone_period(50);
        // Random periods over a wide range.
        for (int i = 0; i < 8; i++) tone_period(20 + int'($urandom_range(180)));
        // Lock, then lose the signal; restart and re-lock after 8 periods.
        in_band_tones(8);
        hold_low(TO_CYC + 100);
        chk("after_to_period", int'(PERIOD), 0);
        chk("after_to_locked", int'(LOCKED), 0);
        in_band_tones(9);
        // Rises exactly TIMEOUT_CYC apart are accepted as samples.
        for (int i = 0; i < 5; i++) tone_period(TO_CYC);
        hold_low(TO_CYC + 50);
        // Reset after two samples, then a fresh four-period average.
        in_band_tones(2);
        tone_with_event(2);
        in_band_tones(5);
        hold_low(TO_CYC + 50);
        // Lock, then an ENABLE gap mid-average; next report starts afresh.
        in_band_tones(9);
        in_band_tones(2);
        tone_with_event(1);
        in_band_tones(5);
        hold_low(TO_CYC + 50);

        repeat (20) step();
        chk("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
